// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state type and default RAM geometry for the block-copy controller
package mem_ctrl_pkg;
   localparam int MC_AW = 7;
   localparam int MC_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } mc_state_t;
endpackage

// File: rtl/mem_copy_ctrl_if.sv
// rtl/mem_copy_ctrl_if.sv - single-port RAM bus between the copy controller and the RAM
interface mem_copy_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int AW = MC_AW,
   parameter int DW = MC_DW
);
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_din;
   logic          mem_we;
   logic [DW-1:0] mem_dout;

   modport master (output mem_adr, output mem_din, output mem_we, input mem_dout);
   modport slave  (input mem_adr, input mem_din, input mem_we, output mem_dout);
endinterface

// File: rtl/mem_copy_ctrl.sv
// rtl/mem_copy_ctrl.sv - block copy controller for a single-port RAM; MEM_COPY_CTRL_FILL_EN adds a fill mode
module mem_copy_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int AW = MC_AW,
   parameter int DW = MC_DW
) (
   input  logic          ck,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW:0]   len,
`ifdef MEM_COPY_CTRL_FILL_EN
   input  logic          fill,
   input  logic [DW-1:0] fill_val,
`endif
   output logic          busy,
   output logic          done,
   mem_copy_ctrl_if.master mem
);

   mc_state_t     state;
   logic [AW-1:0] sp;
   logic [AW-1:0] dp;
   logic [AW:0]   cnt;
   logic [DW-1:0] data_buf;
   logic          fill_q;
   logic          fill_cmd;
   logic [DW-1:0] fill_data;

`ifdef MEM_COPY_CTRL_FILL_EN
   assign fill_cmd  = fill;
   assign fill_data = fill_val;
`else
   assign fill_cmd  = 1'b0;
   assign fill_data = '0;
`endif

   // data_buf doubles as the write-data register; in fill mode it holds the fill value
   assign mem.mem_din = data_buf;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sp          <= '0;
         dp          <= '0;
         cnt         <= '0;
         data_buf    <= '0;
         fill_q      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem.mem_we  <= 1'b0;
         mem.mem_adr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sp     <= src;
                  dp     <= dst;
                  cnt    <= len;
                  fill_q <= fill_cmd;
                  busy   <= 1'b1;
                  if (fill_cmd)
                     data_buf <= fill_data;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (fill_cmd) begin
                     state       <= WRITE;
                     mem.mem_adr <= dst;
                     mem.mem_we  <= 1'b1;
                  end else begin
                     state       <= READ;
                     mem.mem_adr <= src;
                  end
               end
            end
            READ: begin
               data_buf    <= mem.mem_dout;
               state       <= WRITE;
               mem.mem_adr <= dp;
               mem.mem_we  <= 1'b1;
            end
            WRITE: begin
               sp  <= sp + 1'b1;
               dp  <= dp + 1'b1;
               cnt <= cnt - 1'b1;
               // outputs are registered, so the next address is computed one state ahead
               if (cnt == (AW+1)'(1)) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  mem.mem_we <= 1'b0;
               end else if (fill_q) begin
                  mem.mem_adr <= dp + 1'b1;
               end else begin
                  state       <= READ;
                  mem.mem_adr <= sp + 1'b1;
                  mem.mem_we  <= 1'b0;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// tb/tb_mem_copy_ctrl.sv - directed bench for mem_copy_ctrl with a behavioural single-port RAM responder
module tb_mem_copy_ctrl;
   import mem_ctrl_pkg::*;

   logic             ck = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [MC_AW-1:0] src = '0;
   logic [MC_AW-1:0] dst = '0;
   logic [MC_AW:0]   len = '0;
`ifdef MEM_COPY_CTRL_FILL_EN
   logic             fill = 1'b0;
   logic [MC_DW-1:0] fill_val = '0;
`endif
   logic             busy;
   logic             done;

   mem_copy_ctrl_if #(.AW(MC_AW), .DW(MC_DW)) bus ();

   mem_copy_ctrl #(.AW(MC_AW), .DW(MC_DW)) dut (
      .ck       (ck),
      .rst_n    (rst_n),
      .start    (start),
      .src      (src),
      .dst      (dst),
      .len      (len),
`ifdef MEM_COPY_CTRL_FILL_EN
      .fill     (fill),
      .fill_val (fill_val),
`endif
      .busy     (busy),
      .done     (done),
      .mem      (bus)
   );

   // RAM responder: synchronous write, asynchronous read; a side port lets the bench preload it
   logic [MC_DW-1:0] ram  [0:(1<<MC_AW)-1];
   logic [MC_DW-1:0] snap [0:(1<<MC_AW)-1];
   logic             pl_we  = 1'b0;
   logic [MC_AW-1:0] pl_adr = '0;
   logic [MC_DW-1:0] pl_dat = '0;

   always @(posedge ck) begin
      if (bus.mem_we)
         ram[bus.mem_adr] <= bus.mem_din;
      else if (pl_we)
         ram[pl_adr] <= pl_dat;
   end
   assign bus.mem_dout = ram[bus.mem_adr];

   always #5 ck = ~ck;

   typedef struct {
      logic [6:0] s;
      logic [6:0] d;
      logic [7:0] n;
      logic [6:0] pa0, pa1;
      logic [7:0] pv0, pv1;
      logic [6:0] ca0, ca1;
      logic [7:0] cv0, cv1;
      int         done_cyc;
      int         we_n;
      int         poke;
   } vec_t;

   vec_t vecs [6];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic poke_ram(input logic [6:0] a, input logic [7:0] d);
      @(negedge ck);
      pl_we  = 1'b1;
      pl_adr = a;
      pl_dat = d;
      @(negedge ck);
      pl_we  = 1'b0;
   endtask

   task automatic take_snap();
      for (int a = 0; a < (1<<MC_AW); a++) snap[a] = ram[a];
   endtask

   task automatic check_untouched(input string name, input logic [6:0] d, input logic [7:0] n);
      int         bad;
      logic [6:0] off;
      bad = 0;
      for (int a = 0; a < (1<<MC_AW); a++) begin
         off = 7'(a) - d;
         if ({1'b0, off} >= n && ram[a] !== snap[a]) bad++;
      end
      check(name, bad, 0);
   endtask

   // Cycle k is the interval between edges E(k-1) and E(k); sampled 1 time unit after E(k-1)
   task automatic run_cmd(input logic [6:0] s, input logic [6:0] d, input logic [7:0] n, input int poke,
                          output int done_cyc, output int done_n, output int we_n, output int idle_cyc);
      @(negedge ck);
      src = s;
      dst = d;
      len = n;
      start = 1'b1;
      @(posedge ck);
      #1;
      start = 1'b0;
      done_cyc = -1;
      done_n   = 0;
      we_n     = 0;
      idle_cyc = -1;
      for (int k = 1; k <= 400; k++) begin
         if (done === 1'b1) begin
            done_n++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (bus.mem_we === 1'b1) we_n++;
         if (busy !== 1'b1) begin
            idle_cyc = k;
            break;
         end
         start = (k == poke);
         if (k == poke) begin
            src = 7'd0;
            dst = 7'd100;
            len = 8'd1;
         end
         @(posedge ck);
         #1;
      end
      start = 1'b0;
   endtask

   initial begin
      int dc, dn, wn, ic;

      vecs[0] = '{7'd2,   7'd6,   8'd2, 7'd2,   7'd3,  8'd22,   8'd33,   7'd6,   7'd7,  8'd22,   8'd33,   5, 2, 3};
      vecs[1] = '{7'd2,   7'd40,  8'd0, 7'd40,  7'd41, 8'h99,   8'h98,   7'd40,  7'd41, 8'h99,   8'h98,   1, 0, 1};
      vecs[2] = '{7'd127, 7'd10,  8'd2, 7'd127, 7'd0,  8'h7F,   8'h11,   7'd10,  7'd11, 8'h7F,   8'h11,   5, 2, 0};
      vecs[3] = '{7'd4,   7'd5,   8'd2, 7'd4,   7'd5,  8'd44,   8'd55,   7'd5,   7'd6,  8'd44,   8'd44,   5, 2, 5};
      vecs[4] = '{7'd50,  7'd127, 8'd2, 7'd50,  7'd51, 8'h5A,   8'hA5,   7'd127, 7'd0,  8'h5A,   8'hA5,   5, 2, 2};
      vecs[5] = '{7'd30,  7'd31,  8'd1, 7'd30,  7'd31, 8'h3C,   8'h00,   7'd31,  7'd30, 8'h3C,   8'h3C,   3, 1, 0};

      repeat (2) @(posedge ck);
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset mem_we", bus.mem_we, 0);
      check("reset mem_adr", bus.mem_adr, 0);
      check("reset mem_din", bus.mem_din, 0);

      for (int a = 0; a < (1<<MC_AW); a++) poke_ram(7'(a), 8'h00);
      @(negedge ck);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         poke_ram(vecs[i].pa0, vecs[i].pv0);
         poke_ram(vecs[i].pa1, vecs[i].pv1);
         take_snap();
         run_cmd(vecs[i].s, vecs[i].d, vecs[i].n, vecs[i].poke, dc, dn, wn, ic);
         check($sformatf("v%0d done cycle", i), dc, vecs[i].done_cyc);
         check($sformatf("v%0d done pulses", i), dn, 1);
         check($sformatf("v%0d we cycles", i), wn, vecs[i].we_n);
         check($sformatf("v%0d busy end", i), ic, vecs[i].done_cyc + 1);
         check($sformatf("v%0d ram[%0d]", i, vecs[i].ca0), ram[vecs[i].ca0], vecs[i].cv0);
         check($sformatf("v%0d ram[%0d]", i, vecs[i].ca1), ram[vecs[i].ca1], vecs[i].cv1);
         check_untouched($sformatf("v%0d untouched words", i), vecs[i].d, vecs[i].n);
      end

      // reset during the second WRITE of a four-word copy
      for (int j = 0; j < 4; j++) begin
         poke_ram(7'(60 + j), 8'(8'hC0 + j));
         poke_ram(7'(70 + j), 8'h00);
      end
      @(negedge ck);
      src = 7'd60;
      dst = 7'd70;
      len = 8'd4;
      start = 1'b1;
      @(posedge ck);
      #1;
      start = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      check("abort pre mem_we", bus.mem_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort mem_we", bus.mem_we, 0);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      @(posedge ck);
      #1;
      check("abort held done", done, 0);
      @(negedge ck);
      rst_n = 1'b1;
      check("abort ram[70]", ram[70], 8'hC0);
      check("abort ram[71]", ram[71], 8'h00);
      run_cmd(7'd60, 7'd70, 8'd4, 0, dc, dn, wn, ic);
      check("restart done cycle", dc, 9);
      check("restart done pulses", dn, 1);
      check("restart we cycles", wn, 4);
      for (int j = 0; j < 4; j++)
         check($sformatf("restart ram[%0d]", 70 + j), ram[70 + j], 8'hC0 + j);

`ifdef MEM_COPY_CTRL_FILL_EN
      for (int j = 20; j < 23; j++) poke_ram(7'(j), 8'h00);
      poke_ram(7'd23, 8'h77);
      take_snap();
      fill = 1'b1;
      fill_val = 8'hA5;
      run_cmd(7'd5, 7'd20, 8'd3, 2, dc, dn, wn, ic);
      fill = 1'b0;
      check("fill done cycle", dc, 4);
      check("fill done pulses", dn, 1);
      check("fill we cycles", wn, 3);
      check("fill busy end", ic, 5);
      for (int j = 20; j < 23; j++)
         check($sformatf("fill ram[%0d]", j), ram[j], 8'hA5);
      check("fill ram[23]", ram[23], 8'h77);
      check_untouched("fill untouched words", 7'd20, 8'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_copy_ctrl.md
# mem_copy_ctrl

Initiator-side controller for the single-port RAM (synchronous write, asynchronous read, shared address). It accepts a block-copy command and drives the RAM's address, data-in and write-enable lines to copy `len` words from `src` to `dst`, one word every two clock cycles. It sits between a command source (CPU-side register or testbench) and the RAM instance.

## Interface
- `AW`, 7, address width (RAM depth 2^AW)
- `DW`, 8, data width
- `ck`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  command strobe, sampled on the rising edge of `ck`
- `src`  in  AW  first source address
- `dst`  in  AW  first destination address
- `len`  in  AW+1  word count, 0..2^AW
- `busy`  out  1  high while a command is executing
- `done`  out  1  one-cycle pulse at command completion
- `mem_adr`  out  AW  to RAM `adr`
- `mem_din`  out  DW  to RAM `dataIN`
- `mem_we`  out  1  to RAM `we`
- `mem_dout`  in  DW  from RAM `dataOUT`, combinational read of `mem_adr`

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: `busy`=0, `mem_we`=0. On `start`=1, latch `src`, `dst` and `len` into internal registers `sp`, `dp` and `cnt`. Go to DONE if `len`=0, otherwise go to READ.
- READ: `mem_adr`=`sp`, `mem_we`=0. At the edge, capture `mem_dout` into `buf`, then go to WRITE.
- WRITE: `mem_adr`=`dp`, `mem_din`=`buf`, `mem_we`=1. At the edge, increment `sp` and `dp` and decrement `cnt`. Go to DONE if `cnt` was 1, otherwise go to READ.
- DONE: `done`=1 for one cycle, `busy`=1, `mem_we`=0. Go to IDLE.
- Address arithmetic is modulo 2^AW, so the address wraps from 2^AW-1 to 0.
- Copy direction is always ascending. If `dst` lies in (`src`, `src`+`len`), the copied pattern repeats; this is defined behaviour, not an error.
- `start` is ignored in READ, WRITE and DONE. A new command is accepted only in IDLE, which is at the earliest the cycle after `done`.
- `mem_we` is a registered state decode and is glitch-free.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_we`=0, `mem_adr`=0, `mem_din`=0, state IDLE, and `sp`, `dp`, `cnt`, `buf`=0.
- When `rst_n` is asserted mid-command, `mem_we` drops immediately (asynchronously) and the command is abandoned. Words already written stay written; no `done` pulse is produced.
- Let edge E0 be the edge that accepts `start`. READ covers E0..E1, the first WRITE covers E1..E2, and the RAM stores the first word at E2.
- For `len`=N≥1, `done` is high in the cycle after edge E(2N). `busy` is high from E0 until the edge that ends DONE.
- For `len`=0, `done` is high in the cycle after E0 and there are no writes.
- Data read in READ reaches the RAM at the next edge; there is no extra pipeline delay.

## Configuration
- Macro: `MEM_COPY_CTRL_FILL_EN`.
- When defined, the block adds ports `fill` (in, 1) and `fill_val` (in, DW), which are latched with `start`.
  - If `fill`=1, the FSM skips READ and loops WRITE→WRITE with `mem_din`=`fill_val`, writing one word per cycle.
  - `done` is high in the cycle after edge E(N). `src` is ignored.
- When undefined, these ports do not exist and every command is a copy.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum `mc_state_t` (IDLE, READ, WRITE, DONE)
  - the default constants `MC_AW`=7 and `MC_DW`=8, shared with the RAM instance.
- No sub-module. Counters, `buf` and the FSM live inline in a single module.
- The bench instantiates the existing RAM as the responder.

## Test plan
- Preload RAM[2]=22, RAM[3]=33; run `src`=2, `dst`=6, `len`=2 → RAM[6]=22, RAM[7]=33. `done` is high in cycle 5 after E0, and `mem_we` is high in exactly two cycles.
- Run `len`=0 → `done` is high in the cycle after E0, `mem_we` never rises and RAM is unchanged.
- Preload RAM[127]=0x7F, RAM[0]=0x11; run `src`=127, `dst`=10, `len`=2 → RAM[10]=0x7F, RAM[11]=0x11 (address wrap).
- Overlap: RAM[4]=44, RAM[5]=55; run `src`=4, `dst`=5, `len`=2 → RAM[5]=44, RAM[6]=44.
- Assert `rst_n`=0 mid-WRITE of a `len`=4 copy → `mem_we`=0 immediately, `busy`=0, no `done`. Re-pulsing `start` after release restarts cleanly.
- With `MEM_COPY_CTRL_FILL_EN`: `fill`=1, `fill_val`=0xA5, `dst`=20, `len`=3 → RAM[20..22]=0xA5 and `done` is high in the cycle after E3. A `start` pulse while `busy` is ignored.
